// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Instruction fetch stage with an IF/ID pipeline register. The PC drives a
// combinational word-indexed ROM. The returned word is captured into IF/ID
// together with its PC. A small FSM (BOOT -> RUN -> HALT) sequences start-up
// and stops fetching on EBREAK or on an out-of-range fetch. Only reset leaves
// HALT.
//
// Parameters
//   RESET_PC   PC value loaded on reset
//   ROM_DEPTH  number of 32-bit words in the instruction ROM
//
// Ports
//   clk              single clock, rising edge
//   reset            synchronous, active-high reset
//   rom_address      word index to the ROM, {2'b00, pc[31:2]} (combinational)
//   rom_instruction  ROM read data for rom_address, valid in the same cycle
//   stall            hold PC and IF/ID
//   flush            replace IF/ID contents with a bubble
//   redirect         load redirect_pc into the PC (taken branch or jump)
//   redirect_pc      redirect target byte address (low two bits discarded)
//   pc               current fetch byte address
//   if_id_instr      IF/ID instruction (NOP when holding a bubble)
//   if_id_pc         IF/ID instruction address
//   if_id_valid      IF/ID holds a real instruction
//   halted           registered, high while the FSM is in HALT
//   fetch_fault      sticky, set by an attempted fetch beyond ROM_DEPTH
//   fetch_count      (only with FETCH_COUNTER_EN) wrapping count of valid
//                    IF/ID loads
//
// Build option
//   FETCH_COUNTER_EN  adds the fetch_count output and its counter
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rom_address,
  input  logic [31:0] rom_instruction,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid,
  output logic        halted,
  output logic        fetch_fault
`ifdef FETCH_COUNTER_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] EBREAK    = 32'h0010_0073;
  localparam logic [31:0] ROM_WORDS = ROM_DEPTH;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t state;
  logic   out_of_range;

  assign rom_address  = {2'b00, pc[31:2]};
  assign out_of_range = (rom_address >= ROM_WORDS);

  // Every IF/ID load of a bubble captures the current pc. That way a killed
  // slot still says where it came from.
  // NOTE: all state is written with non-blocking assignments so every branch
  // sees the pre-edge pc/state, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      if_id_instr <= NOP;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_fault <= 1'b0;
`ifdef FETCH_COUNTER_EN
      fetch_count <= '0;
`endif
    end else begin
      case (state)
        // One settling cycle: bubble into IF/ID, pc untouched.
        BOOT: begin
          if_id_instr <= NOP;
          if_id_pc    <= pc;
          if_id_valid <= 1'b0;
          state       <= RUN;
        end

        RUN: begin
          if (redirect) begin
            // Redirect wins over stall and flush; the wrong-path slot dies.
            pc          <= {redirect_pc[31:2], 2'b00};
            if_id_instr <= NOP;
            if_id_pc    <= pc;
            if_id_valid <= 1'b0;
          end else if (stall) begin
            if (flush) begin
              if_id_instr <= NOP;
              if_id_pc    <= pc;
              if_id_valid <= 1'b0;
            end
          end else if (out_of_range) begin
            if_id_instr <= NOP;
            if_id_pc    <= pc;
            if_id_valid <= 1'b0;
            fetch_fault <= 1'b1;
            halted      <= 1'b1;
            state       <= HALT;
          end else if (flush) begin
            if_id_instr <= NOP;
            if_id_pc    <= pc;
            if_id_valid <= 1'b0;
            pc          <= pc + 32'd4;
          end else begin
            if_id_instr <= rom_instruction;
            if_id_pc    <= pc;
            if_id_valid <= 1'b1;
`ifdef FETCH_COUNTER_EN
            fetch_count <= fetch_count + 32'd1;
`endif
            // EBREAK is delivered downstream, but the PC parks on it.
            if (rom_instruction == EBREAK) begin
              halted <= 1'b1;
              state  <= HALT;
            end else begin
              pc <= pc + 32'd4;
            end
          end
        end

        // Parked: pc frozen, redirect ignored, IF/ID drains to bubbles.
        HALT: begin
          if (!stall || flush) begin
            if_id_instr <= NOP;
            if_id_pc    <= pc;
            if_id_valid <= 1'b0;
          end
        end

        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Self-checking bench for instruction_fetch. A behavioural model tracks the
// fetch stage one cycle at a time from the current inputs. Every cycle, the
// model's pc, IF/ID contents, halted and fetch_fault are compared with the
// DUT outputs. Directed steps cover start-up, stall, redirect priority, EBREAK,
// out-of-range fetch and the counter. A randomized run follows.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          ROM_DEPTH = 64;
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] EBREAK    = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        reset, stall, flush, redirect;
  logic [31:0] redirect_pc, rom_address, rom_instruction, pc;
  logic [31:0] if_id_instr, if_id_pc;
  logic        if_id_valid, halted, fetch_fault;
`ifdef FETCH_COUNTER_EN
  logic [31:0] fetch_count;
`endif

  logic [31:0] rom [0:ROM_DEPTH-1];

  instruction_fetch #(.RESET_PC(RESET_PC), .ROM_DEPTH(ROM_DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .rom_address    (rom_address),
    .rom_instruction(rom_instruction),
    .stall          (stall),
    .flush          (flush),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .pc             (pc),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_valid    (if_id_valid),
    .halted         (halted),
    .fetch_fault    (fetch_fault)
`ifdef FETCH_COUNTER_EN
    ,
    .fetch_count    (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  // Combinational ROM; words beyond the depth read back as junk.
  always_comb begin
    rom_instruction = 32'hDEAD_BEEF;
    if (rom_address < ROM_DEPTH) rom_instruction = rom[rom_address[5:0]];
  end

  // Reference model state. mode: 0 = boot, 1 = run, 2 = halt.
  int          m_mode;
  logic [31:0] m_pc, m_instr, m_ipc, m_count;
  logic        m_valid, m_halted, m_fault;

  int checks   = 0;
  int failures = 0;
  int vcount;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_bubble();
    m_instr = NOP;
    m_ipc   = m_pc;
    m_valid = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [31:0] word;
    if (reset) begin
      m_mode  = 0;
      m_pc    = RESET_PC;
      m_instr = NOP;
      m_ipc   = 32'h0;
      m_valid = 1'b0;
      m_fault = 1'b0;
      m_count = 32'h0;
    end else if (m_mode == 0) begin
      m_bubble();
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (redirect) begin
        m_bubble();
        m_pc = redirect_pc & 32'hFFFF_FFFC;
      end else if (stall) begin
        if (flush) m_bubble();
      end else if (m_pc / 4 >= ROM_DEPTH) begin
        m_bubble();
        m_fault = 1'b1;
        m_mode  = 2;
      end else if (flush) begin
        m_bubble();
        m_pc = m_pc + 4;
      end else begin
        word    = rom[m_pc / 4];
        m_instr = word;
        m_ipc   = m_pc;
        m_valid = 1'b1;
        m_count = m_count + 1;
        if (word == EBREAK) m_mode = 2;
        else m_pc = m_pc + 4;
      end
    end else begin
      if (!stall || flush) m_bubble();
    end
    m_halted = (m_mode == 2);
  endtask

  task automatic compare_all();
    check("pc", pc, m_pc);
    check("rom_address", rom_address, m_pc >> 2);
    check("if_id_instr", if_id_instr, m_instr);
    check("if_id_pc", if_id_pc, m_ipc);
    check("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
    check("halted", {31'b0, halted}, {31'b0, m_halted});
    check("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
`ifdef FETCH_COUNTER_EN
    check("fetch_count", fetch_count, m_count);
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    if (if_id_valid === 1'b1) vcount++;
    compare_all();
  endtask

  task automatic drive(input logic r, input logic s, input logic f,
                       input logic rd, input logic [31:0] rpc);
    reset       = r;
    stall       = s;
    flush       = f;
    redirect    = rd;
    redirect_pc = rpc;
  endtask

  initial begin
    for (int i = 0; i < ROM_DEPTH; i++) rom[i] = NOP;
    rom[0] = 32'h0050_0093;
    rom[1] = 32'h0010_0113;
    rom[2] = 32'h0020_81B3;
    rom[3] = 32'h0000_0013;
    rom[5] = EBREAK;
    vcount = 0;

    // Reset state.
    drive(1, 0, 0, 0, 0);
    tick();
    check("rst_pc", pc, RESET_PC);
    check("rst_instr", if_id_instr, NOP);
    check("rst_ipc", if_id_pc, 32'h0);
    check("rst_valid", {31'b0, if_id_valid}, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'h0);
    check("rst_fault", {31'b0, fetch_fault}, 32'h0);
    tick();

    // BOOT: one bubble, pc held.
    drive(0, 0, 0, 0, 0);
    tick();
    check("boot_valid", {31'b0, if_id_valid}, 32'h0);
    check("boot_pc", pc, 32'h0);

    // First two fetches.
    for (int k = 0; k < 2; k++) begin
      check("seq_rom_addr", rom_address, k);
      tick();
      check("seq_ipc", if_id_pc, 4 * k);
      check("seq_valid", {31'b0, if_id_valid}, 32'h1);
    end

    // Stall three cycles while pc = 8.
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_pc", pc, 32'h8);
      check("stall_ipc", if_id_pc, 32'h4);
      check("stall_instr", if_id_instr, 32'h0010_0113);
    end
    stall = 1'b0;
    check("resume_rom_addr", rom_address, 32'h2);
    tick();
    check("resume_ipc", if_id_pc, 32'h8);
    check("resume_instr", if_id_instr, 32'h0020_81B3);

    // Redirect together with stall and flush; target low bits dropped.
    drive(0, 1, 1, 1, 32'h0000_0013);
    tick();
    check("redir_pc", pc, 32'h10);
    check("redir_valid", {31'b0, if_id_valid}, 32'h0);
    check("redir_instr", if_id_instr, NOP);

    // Fetch word 4, then EBREAK at word 5.
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    check("ebreak_instr", if_id_instr, EBREAK);
    check("ebreak_valid", {31'b0, if_id_valid}, 32'h1);
    check("ebreak_pc", pc, 32'h14);
    check("ebreak_halted", {31'b0, halted}, 32'h1);
    drive(0, 0, 0, 1, 32'h0);
    tick();
    check("halt_redir_pc", pc, 32'h14);
    tick();

    // Out-of-range fetch after a redirect to 0x100.
    drive(1, 0, 0, 0, 0);
    tick();
    check("rst2_halted", {31'b0, halted}, 32'h0);
    drive(0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 32'h100);
    tick();
    check("oor_pc", pc, 32'h100);
    drive(0, 0, 0, 0, 0);
    tick();
    check("oor_fault", {31'b0, fetch_fault}, 32'h1);
    check("oor_halted", {31'b0, halted}, 32'h1);
    check("oor_valid", {31'b0, if_id_valid}, 32'h0);
    tick();
    drive(1, 0, 0, 0, 0);
    tick();
    check("oor_rst_fault", {31'b0, fetch_fault}, 32'h0);
    check("oor_rst_pc", pc, RESET_PC);
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    check("restart_ipc", if_id_pc, RESET_PC);
    check("restart_valid", {31'b0, if_id_valid}, 32'h1);

    // Randomized run against the model. The ROM holds no EBREAK here.
    for (int i = 0; i < ROM_DEPTH; i++) begin
      rom[i] = $urandom;
      if (rom[i] == EBREAK) rom[i] = rom[i] ^ 32'h1;
    end
    drive(1, 0, 0, 0, 0);
    tick();
    for (int n = 0; n < 800; n++) begin
      reset       = ($urandom_range(0, 59) == 0);
      stall       = ($urandom_range(0, 3) == 0);
      flush       = ($urandom_range(0, 5) == 0);
      redirect    = ($urandom_range(0, 7) == 0);
      redirect_pc = $urandom_range(0, 300);
      if (m_pc / 4 >= ROM_DEPTH) flush = 1'b0;
      tick();
    end

    // Ten valid fetches plus two flushes, then reset mid-sequence.
    drive(1, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    vcount = 0;
    for (int k = 0; k < 12; k++) begin
      flush = (k == 3 || k == 7);
      tick();
    end
    flush = 1'b0;
    check("valid_loads", vcount, 32'd10);
`ifdef FETCH_COUNTER_EN
    check("count_10", fetch_count, 32'd10);
`endif
    tick();
    reset = 1'b1;
    tick();
`ifdef FETCH_COUNTER_EN
    check("count_rst", fetch_count, 32'd0);
`endif
    check("final_pc", pc, RESET_PC);
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 SHALL have parameter ROM_DEPTH, default 64, number of 32-bit words in the instruction ROM.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rom_address  output  32  word index to ROM, combinational {2'b00, pc[31:2]}.
REQ-006 SHALL have port rom_instruction  input  32  ROM read data, valid in the same cycle as rom_address.
REQ-007 SHALL have port stall  input  1  hold PC and IF/ID register.
REQ-008 SHALL have port flush  input  1  replace the IF/ID contents with a bubble.
REQ-009 SHALL have port redirect  input  1  load redirect_pc into the PC (taken branch or jump).
REQ-010 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-011 SHALL have port pc  output  32  current fetch byte address.
REQ-012 SHALL have ports if_id_instr / if_id_pc / if_id_valid  output  32/32/1  IF/ID pipeline register.
REQ-013 SHALL have port halted  output  1  high while the FSM is in HALT.
REQ-014 SHALL have port fetch_fault  output  1  sticky; set when an out-of-range fetch is attempted.

Function
REQ-015 SHALL implement FSM states BOOT, RUN and HALT; BOOT SHALL last exactly one cycle (IF/ID loads a bubble, PC holds), then move to RUN.
REQ-016 Bubble SHALL be defined as if_id_instr=32'h00000013 (NOP), if_id_pc=pc, if_id_valid=0.
REQ-017 In RUN, when not stalled and not redirected, the block SHALL load IF/ID with {rom_instruction, pc, valid=1} and set pc<=pc+4, wrapping modulo 2^32; fetch-to-IF/ID latency is 1 cycle.
REQ-018 Redirect SHALL take priority over stall and flush: pc<={redirect_pc[31:2],2'b00}, IF/ID<=bubble; the low two target bits SHALL be discarded.
REQ-019 When stall=1 and redirect=0, the block SHALL hold pc; IF/ID SHALL hold unless flush=1, in which case it loads a bubble.
REQ-020 When flush=1 and stall=0 and redirect=0, IF/ID SHALL load a bubble and pc SHALL advance by 4.
REQ-021 In RUN, with stall=0 and redirect=0, a fetched word equal to 32'h00100073 (EBREAK) SHALL load IF/ID valid, hold pc and move to HALT.
REQ-022 In RUN, with stall=0 and redirect=0, a fetch with pc[31:2] >= ROM_DEPTH SHALL load a bubble, set fetch_fault=1, hold pc and move to HALT.
REQ-023 In HALT, pc SHALL hold and redirect SHALL be ignored; IF/ID SHALL load a bubble whenever stall=0; only reset exits HALT.
REQ-024 halted SHALL equal (state==HALT), registered, with no combinational path from the inputs.

Reset
REQ-025 Reset SHALL override all other inputs in the cycle it is sampled, including mid-stall, mid-redirect and HALT.
REQ-026 On reset: pc=RESET_PC, if_id_instr=32'h00000013, if_id_pc=0, if_id_valid=0, halted=0, fetch_fault=0, fetch_count=0, state=BOOT.

Configuration
REQ-027 With macro FETCH_COUNTER_EN defined, the block SHALL add output fetch_count (32 bits) that increments, wrapping, on every cycle in which IF/ID loads if_id_valid=1.
REQ-028 Without FETCH_COUNTER_EN, the port and counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Reset with RESET_PC=0, ROM words 0..3 = 0x00500093, 0x00100113, 0x002081B3, 0x00000013 -> BOOT bubble, then if_id_pc 0,4,8,12 on consecutive cycles with valid=1, and rom_address 0,1,2,3.
REQ-030 stall high for 3 cycles at pc=8 -> pc, if_id_instr and if_id_pc held for 3 cycles; fetch resumes at pc=8 with no duplicate or dropped word.
REQ-031 redirect=1, stall=1 and flush=1 together with redirect_pc=0x00000013 -> next pc=0x10, IF/ID bubble (valid=0, instr 0x13).
REQ-032 Word 5 = 0x00100073 -> IF/ID holds the EBREAK with valid=1, pc stays 0x14, halted=1 next cycle; a later redirect to 0 leaves pc at 0x14.
REQ-033 redirect_pc=0x100 with ROM_DEPTH=64 -> next fetch gives bubble, fetch_fault=1 and halted=1; reset then clears both and fetch restarts at RESET_PC.
REQ-034 With FETCH_COUNTER_EN, 10 valid fetches plus 2 flushes -> fetch_count=10; with reset asserted mid-sequence -> fetch_count=0 on the next cycle.
